fpmul_feeder: RTL and testbench
===============================

# fpmul_feeder

Operand sequencer and result collector wrapped around the `fpmultiplier` core.
- Buffers operand pairs from an upstream valid/ready source in a small FIFO.
- Serialises each pair onto the core's single 32-bit operand port in the two cycles after the core signals ready.
- Tags each core pass as real or dummy.
- Captures the product of real passes into a 2-entry result queue with valid/ready output.

## Interface

Parameters:
- `DEPTH`, 4: operand-pair FIFO entries (power of two, ≥2).

Ports:
- `clock` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a` in 32: operand A (IEEE-754 single).
- `in_b` in 32: operand B.
- `mul_ready` in 1: core `ready`; high exactly in the core's start cycle.
- `mul_product` in 32: core `product`.
- `mul_operand` out 32: drives core input `a`.
- `res_valid` out 1: result queue non-empty.
- `res_ready` in 1: downstream accepts head.
- `res_product` out 32: head of result queue.
- `pending` out 4: FIFO occupancy + in-flight job (0..DEPTH+1).

## Operation

Core contract:
- The core free-runs.
- It samples `a` in the cycle after its ready cycle (A) and the cycle after that (B).
- It returns to ready 10, 13 or 16 cycles after the previous ready cycle.
- During each ready cycle (except the first after reset) `mul_product` holds the previous pass's result.
- The feeder never stalls the core.

State machine, `state` ∈ {WAIT, SENDA, SENDB}:
- WAIT, `mul_ready`=1 → SENDA. Every other WAIT cycle stays in WAIT.
- SENDA → SENDB unconditionally.
- SENDB → WAIT unconditionally.
- `mul_ready`=1 while in SENDA or SENDB is a protocol violation: ignore it; the state sequence is unchanged.

Ready-cycle actions, executed in the WAIT cycle where `mul_ready`=1:
- Capture: if `inflight`=1, push `mul_product` into the result queue.
- Issue: if the FIFO is non-empty and (queue occupancy after this cycle's push and pop) ≤ 1:
  - pop the FIFO head into the `opA`/`opB` registers;
  - set `inflight`=1.
- Otherwise set `inflight`=0, and the coming pass is a dummy.

Operand drive:
- `mul_operand` = `opA` in SENDA and `opB` in SENDB, when `inflight`=1.
- `mul_operand` = 0 in all other cycles, including dummy passes.

Input FIFO:
- Push on `in_valid && in_ready`; 64-bit entries.
- Simultaneous push and pop when full is not allowed: `in_ready` depends on occupancy only.
- Pointers wrap modulo DEPTH.

Result queue:
- Depth 2; pop on `res_valid && res_ready`.
- Simultaneous push and pop are both honoured.
- The issue rule guarantees a push never finds the queue full, so results are never dropped.

Ordering:
- Results leave in operand-arrival order.
- Dummy products are never captured.

Reset values:
- `state`=WAIT, `inflight`=0.
- FIFO and result queue empty.
- `in_ready`=1, `res_valid`=0, `res_product`=0, `mul_operand`=0, `pending`=0.
- Reset mid-pass discards all in-flight and queued work. The core's `nreset` is tied to `~reset` at the top level, so the core restarts in its start state.

## Timing

- `in_ready` and `res_valid` are registered-state functions; there is no combinational path from `in_valid` or `res_ready`.
- Issue latency: a pair accepted at cycle t is popped at the first `mul_ready` cycle strictly after t.
  - Operand A is on `mul_operand` in the following cycle; B is on it one cycle later.
- Result: `res_valid` rises the cycle after the next `mul_ready` cycle. This is 10, 13 or 16 cycles after the issue ready-cycle, depending on the path the core takes.
- Throughput: one pair per core pass while the FIFO is non-empty and the result queue is drained.
- `pending` updates the cycle after any push, pop or capture.

## Test plan

1. **Single pair.** Reset, then push A=0x3FC00000, B=0x3FC00000 (1.5×1.5) with `res_ready`=1.
   - Required: `mul_operand` = 0x3FC00000 in both SENDA and SENDB.
   - Required: one `res_valid` pulse with 0x40100000; `pending` returns to 0.
2. **Back-to-back fill.** Push 5 pairs with DEPTH=4.
   - Required: `in_ready` drops after the 4th push while the 1st is still queued.
   - Required: five results in order: 2.0×4.0=0x41000000, 1.5×1.5=0x40100000, 0×5.0=0x00000000, inf×2.0=0x7F800000, NaN×1.0=0x7FAA5452.
3. **Idle core.** No input for 100 cycles.
   - Required: `mul_operand` constantly 0, `res_valid` never asserts, `state` cycles WAIT→SENDA→SENDB on each `mul_ready`.
4. **Backpressure.** Hold `res_ready`=0 and push 4 pairs.
   - Required: exactly 2 results queue; no further issue occurs (`pending` stays 2).
   - Release `res_ready`: the remaining results follow in order, with none lost or duplicated.
5. **Reset mid-pass.** Assert `reset` during SENDB of an issued pair.
   - Required: all outputs at reset values in the same cycle.
   - Required: after release, no stale result appears and a new pair completes correctly.
6. **Simultaneous events.** Time a result-queue pop, an input push and the `mul_ready` capture into the same cycle.
   - Required: occupancy counts stay consistent and no entry is dropped.

Source files
------------

// File: rtl/fpmul_feeder.sv
// Operand sequencer / result collector around the fpmultiplier core: buffers
// operand pairs, serialises A then B after each core ready, collects real products.
module fpmul_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        mul_ready,
  input  logic [31:0] mul_product,
  output logic [31:0] mul_operand,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_product,
  output logic [3:0]  pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_SENDA = 2'd1;
  localparam logic [1:0] S_SENDB = 2'd2;

  logic [1:0]             r_state;
  logic [DEPTH-1:0][63:0] r_fifo;
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_fcnt;
  logic [1:0][31:0]       r_rq;
  logic                   r_rq_wp, r_rq_rp;
  logic [1:0]             r_rq_cnt;
  logic [31:0]            r_opa, r_opb;
  logic                   r_inflight;

  logic       w_fire, w_in_push, w_rq_push, w_rq_pop, w_issue;
  logic [1:0] w_rq_next;

  // Ready-cycle actions only happen from WAIT; a ready seen mid-pass is ignored.
  assign w_fire    = (r_state == S_WAIT) && mul_ready;
  assign w_in_push = in_valid && in_ready;
  assign w_rq_push = w_fire && r_inflight;
  assign w_rq_pop  = res_valid && res_ready;
  assign w_rq_next = r_rq_cnt + 2'(w_rq_push) - 2'(w_rq_pop);
  // Leaving room for the product of this issue keeps the result queue from overflowing.
  assign w_issue   = w_fire && (r_fcnt != '0) && (w_rq_next <= 2'd1);

  assign in_ready    = (r_fcnt != (AW+1)'(DEPTH));
  assign res_valid   = (r_rq_cnt != 2'd0);
  assign res_product = r_rq[r_rq_rp];
  assign pending     = 4'(r_fcnt) + 4'(r_inflight);

  always_comb begin
    mul_operand = 32'd0;
    if (r_inflight && r_state == S_SENDA) mul_operand = r_opa;
    else if (r_inflight && r_state == S_SENDB) mul_operand = r_opb;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fifo <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_in_push) begin
        r_fifo[r_wptr] <= {in_a, in_b};
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_issue) r_rptr <= r_rptr + AW'(1);
      r_fcnt <= r_fcnt + (AW+1)'(w_in_push) - (AW+1)'(w_issue);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_WAIT;
      r_opa      <= '0;
      r_opb      <= '0;
      r_inflight <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT:  if (mul_ready) r_state <= S_SENDA;
        S_SENDA: r_state <= S_SENDB;
        S_SENDB: r_state <= S_WAIT;
        default: r_state <= S_WAIT;
      endcase
      if (w_issue) begin
        {r_opa, r_opb} <= r_fifo[r_rptr];
        r_inflight     <= 1'b1;
      end else if (w_fire) begin
        r_inflight <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rq     <= '0;
      r_rq_wp  <= 1'b0;
      r_rq_rp  <= 1'b0;
      r_rq_cnt <= 2'd0;
    end else begin
      if (w_rq_push) begin
        r_rq[r_rq_wp] <= mul_product;
        r_rq_wp       <= ~r_rq_wp;
      end
      if (w_rq_pop) r_rq_rp <= ~r_rq_rp;
      r_rq_cnt <= w_rq_next;
    end
  end

endmodule

// File: tb/tb_fpmul_feeder.sv
// Bench for fpmul_feeder: a behavioural core stand-in plus a queue-based
// reference of the feeder, checked every cycle and at directed checkpoints.
module tb_fpmul_feeder;
  localparam int DEPTH = 4;

  logic        clock, reset, in_valid, in_ready, mul_ready, res_valid, res_ready;
  logic [31:0] in_a, in_b, mul_product, mul_operand, res_product;
  logic [3:0]  pending;

  fpmul_feeder #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_ready(mul_ready), .mul_product(mul_product),
    .mul_operand(mul_operand), .res_valid(res_valid), .res_ready(res_ready),
    .res_product(res_product), .pending(pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] a; logic [31:0] b; } pair_t;

  int          n_chk, n_pass;
  pair_t       acc_q[$];
  logic [31:0] res_q[$];
  logic [31:0] out_log[$];
  pair_t       m_op;
  bit          m_inflight;
  int          core_cnt, core_phase;
  logic [31:0] core_a, core_b, core_prod, last_real_a, last_real_b;
  bit          core_prev;
  int          n_acc, n_pop, n_disc, n_rdy;
  bit          drv_valid, drv_rready;
  logic [31:0] drv_a, drv_b;
  bit          last_acc, last_rdy, arm_rst, rst_hit, rv_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Stand-in for the multiplier: known IEEE cases from the plan, a hash otherwise.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40800000: fmul = 32'h41000000;
      64'h3FC00000_3FC00000: fmul = 32'h40100000;
      64'h00000000_40A00000: fmul = 32'h00000000;
      64'h7F800000_40000000: fmul = 32'h7F800000;
      64'h7FAA5452_3F800000: fmul = 32'h7FAA5452;
      default:               fmul = (a ^ {b[15:0], b[31:16]}) + 32'h1357;
    endcase
  endfunction

  task automatic model_reset();
    n_disc += acc_q.size() + res_q.size() + int'(m_inflight);
    acc_q.delete();
    res_q.delete();
    m_inflight = 0;
    core_cnt   = 2;
    core_phase = 0;
    core_prev  = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_product", res_product, 32'd0);
    chk("rst_mul_operand", mul_operand, 32'd0);
    chk("rst_pending", pending, 4'd0);
  endtask

  task automatic tick();
    logic [31:0] exp_op;
    bit rdy, pop, acc;
    @(negedge clock);
    chk("in_ready", in_ready, acc_q.size() < DEPTH);
    chk("res_valid", res_valid, res_q.size() != 0);
    if (res_q.size() != 0) chk("res_product", res_product, res_q[0]);
    chk("pending", pending, acc_q.size() + int'(m_inflight));
    exp_op = 32'd0;
    if (m_inflight && core_phase == 1) exp_op = m_op.a;
    else if (m_inflight && core_phase == 2) exp_op = m_op.b;
    chk("mul_operand", mul_operand, exp_op);
    if (res_valid) rv_seen = 1;
    if (arm_rst && core_phase == 2 && m_inflight) begin
      arm_rst = 0;
      rst_hit = 1;
      reset = 1'b1;
      #1;
      check_reset_vals();
      model_reset();
      in_valid = 1'b0; mul_ready = 1'b0; res_ready = 1'b0;
      @(posedge clock);
      #2 reset = 1'b0;
      last_acc = 0;
      last_rdy = 0;
      return;
    end
    if (core_phase == 1) core_a = mul_operand;
    else if (core_phase == 2) begin
      core_b    = mul_operand;
      core_prod = fmul(core_a, core_b);
      if (m_inflight) begin last_real_a = core_a; last_real_b = core_b; end
    end
    rdy = (core_cnt == 0);
    mul_ready   = rdy;
    mul_product = core_prev ? core_prod : $urandom;
    in_valid    = drv_valid;
    in_a        = drv_a;
    in_b        = drv_b;
    res_ready   = drv_rready;
    pop = (res_q.size() != 0) && drv_rready;
    acc = drv_valid && (acc_q.size() < DEPTH);
    if (pop) begin
      out_log.push_back(res_product);
      void'(res_q.pop_front());
      n_pop++;
    end
    if (rdy) begin
      n_rdy++;
      if (m_inflight) res_q.push_back(fmul(m_op.a, m_op.b));
      if (acc_q.size() != 0 && res_q.size() <= 1) begin
        m_op = acc_q.pop_front();
        m_inflight = 1;
      end else m_inflight = 0;
    end
    if (acc) begin
      acc_q.push_back(pair_t'({drv_a, drv_b}));
      n_acc++;
    end
    last_acc = acc;
    last_rdy = rdy;
    if (rdy) begin
      core_phase = 1;
      core_prev  = 1;
      case ($urandom_range(0, 2))
        0:       core_cnt = 9;
        1:       core_cnt = 12;
        default: core_cnt = 15;
      endcase
    end else begin
      core_cnt--;
      core_phase = (core_phase == 1) ? 2 : 0;
    end
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    drv_valid = 1; drv_a = a; drv_b = b;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("push_accepted", {31'd0, last_acc}, 32'd1);
    drv_valid = 0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_rdy) break;
    end
    chk("ready_seen", {31'd0, last_rdy}, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    drv_rready = 1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (acc_q.size() == 0 && res_q.size() == 0 && !m_inflight) begin done = 1; break; end
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base, r0;
    bit hit;
    pair_t p[4];
    logic [31:0] t2_exp[5];
    n_chk = 0; n_pass = 0; n_acc = 0; n_pop = 0; n_disc = 0; n_rdy = 0;
    drv_valid = 0; drv_rready = 1; drv_a = 0; drv_b = 0;
    arm_rst = 0; rst_hit = 0; rv_seen = 0; m_op = '0;
    core_a = 0; core_b = 0; core_prod = 0; last_real_a = 0; last_real_b = 0;
    in_valid = 0; in_a = 0; in_b = 0; mul_ready = 0; mul_product = 0; res_ready = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_vals();
    model_reset();
    @(posedge clock);
    #2 reset = 1'b0;

    // 1: single pair
    base = out_log.size();
    push_pair(32'h3FC00000, 32'h3FC00000);
    drain();
    chk("t1_opA", last_real_a, 32'h3FC00000);
    chk("t1_opB", last_real_b, 32'h3FC00000);
    chk("t1_count", out_log.size() - base, 1);
    if (out_log.size() > base) chk("t1_prod", out_log[base], 32'h40100000);
    tick();
    chk("t1_pending", pending, 4'd0);

    // 2: back-to-back fill right after a ready so the first pair stays queued
    t2_exp = '{32'h41000000, 32'h40100000, 32'h00000000, 32'h7F800000, 32'h7FAA5452};
    base = out_log.size();
    wait_ready();
    push_pair(32'h40000000, 32'h40800000);
    push_pair(32'h3FC00000, 32'h3FC00000);
    push_pair(32'h00000000, 32'h40A00000);
    push_pair(32'h7F800000, 32'h40000000);
    @(posedge clock);
    #1;
    chk("t2_in_ready_low", in_ready, 1'b0);
    chk("t2_pending_full", pending, 4'd4);
    push_pair(32'h7FAA5452, 32'h3F800000);
    drain();
    chk("t2_count", out_log.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (out_log.size() > base + i) chk("t2_prod", out_log[base + i], t2_exp[i]);

    // 3: idle core
    rv_seen = 0;
    r0 = n_rdy;
    repeat (100) tick();
    chk("t3_res_valid_never", {31'd0, rv_seen}, 32'd0);
    chk("t3_ready_passes", {31'd0, (n_rdy - r0) >= 6}, 32'd1);

    // 4: backpressure
    drv_rready = 0;
    base = out_log.size();
    for (int i = 0; i < 4; i++) begin
      p[i] = pair_t'({$urandom, $urandom});
      push_pair(p[i].a, p[i].b);
    end
    repeat (60) tick();
    chk("t4_pending", pending, 4'd2);
    chk("t4_res_valid", res_valid, 1'b1);
    chk("t4_none_out", out_log.size() - base, 0);
    drain();
    chk("t4_count", out_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (out_log.size() > base + i) chk("t4_order", out_log[base + i], fmul(p[i].a, p[i].b));

    // 5: reset during SENDB of a real pass
    push_pair($urandom, $urandom);
    rst_hit = 0;
    arm_rst = 1;
    for (int i = 0; i < 60 && !rst_hit; i++) tick();
    arm_rst = 0;
    chk("t5_reset_hit", {31'd0, rst_hit}, 32'd1);
    base = out_log.size();
    repeat (40) tick();
    chk("t5_no_stale", out_log.size() - base, 0);
    push_pair(32'h3FC00000, 32'h3FC00000);
    drain();
    chk("t5_count", out_log.size() - base, 1);
    if (out_log.size() > base) chk("t5_prod", out_log[base], 32'h40100000);

    // 6: pop, push and capture in the same cycle
    drv_rready = 0;
    base = out_log.size();
    push_pair($urandom, $urandom);
    push_pair($urandom, $urandom);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (core_cnt == 0 && res_q.size() == 1 && m_inflight) begin
        drv_rready = 1; drv_valid = 1; drv_a = $urandom; drv_b = $urandom;
        tick();
        hit = last_acc && last_rdy;
        drv_valid = 0;
      end else tick();
    end
    chk("t6_coincide", {31'd0, hit}, 32'd1);
    drain();
    chk("t6_count", out_log.size() - base, 3);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drv_valid  = $urandom_range(0, 1) == 1;
      drv_a      = $urandom;
      drv_b      = $urandom;
      drv_rready = $urandom_range(0, 9) < 7;
      tick();
    end
    drv_valid = 0;
    drain();
    chk("total_results", n_pop, n_acc - n_disc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
